// File: rtl/core_test_sequencer_pkg.sv
// Shared types for the core self-test sequencer.
//   data_width   : lisp core word width
//   fail_code_t  : batch failure reason reported on fail_code
//   seq_state_t  : sequencer FSM states
package core_test_sequencer_pkg;

  localparam int data_width = 16;

  typedef enum logic [1:0] {
    FAIL_NONE       = 2'd0,
    FAIL_VERIFY     = 2'd1,
    FAIL_CORE_ERROR = 2'd2,
    FAIL_TIMEOUT    = 2'd3
  } fail_code_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_CORE,
    ST_LOAD,
    ST_VERIFY,
    ST_START,
    ST_RUN,
    ST_CHECK,
    ST_NEXT,
    ST_FAIL,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/core_test_sequencer_watchdog.sv
// Cycle watchdog for the RUN phase of the test sequencer.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : synchronous clear to 0 (has priority over enable)
//   enable   : count one per cycle, saturating at TIMEOUT
//   expired  : count has reached TIMEOUT
module seq_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/core_test_sequencer.sv
// On-chip self-test harness for the lisp core. For each table entry it copies
// the heap image from ROM into core RAM, reads it back to verify, resets and
// starts the core on the table expression, and waits for Halt/Error under a
// watchdog. Stops on the first failure and latches result / pass count.
//   clk, rst                 : clock, asynchronous active-low reset
//   go                       : start a batch (sampled only in IDLE/DONE)
//   img_addr / img_data      : image ROM port (combinational data)
//   tbl_idx / tbl_expr / tbl_expected : test table port (combinational data)
//   mem_we/addr/wdata/rdata  : core RAM port, read latency 1
//   core_rst/start/expr      : core control; core_halt/error/val/err_code status
//   busy, done, pass, fail_code, fail_info, result, pass_count : batch status
module core_test_sequencer
  import core_test_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = data_width,
  parameter int ADDR_WIDTH  = 10,
  parameter int IMAGE_DEPTH = 1024,
  parameter int NUM_TESTS   = 4,
  parameter int RST_CYCLES  = 3,
  parameter int TIMEOUT     = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  output logic [ADDR_WIDTH-1:0]        img_addr,
  input  logic [DATA_WIDTH-1:0]        img_data,
  output logic [$clog2(NUM_TESTS):0]   tbl_idx,
  input  logic [DATA_WIDTH-1:0]        tbl_expr,
  input  logic [DATA_WIDTH-1:0]        tbl_expected,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         core_rst,
  output logic                         core_start,
  output logic [DATA_WIDTH-1:0]        core_expr,
  input  logic                         core_halt,
  input  logic                         core_error,
  input  logic [DATA_WIDTH-1:0]        core_val,
  input  logic [DATA_WIDTH-1:0]        core_err_code,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code,
  output logic [DATA_WIDTH-1:0]        fail_info,
  output logic [DATA_WIDTH-1:0]        result,
  output logic [$clog2(NUM_TESTS):0]   pass_count
);

  localparam int IW     = $clog2(NUM_TESTS) + 1;
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam int RW     = $clog2(RST_CYCLES + 1);
  localparam int CNT_W  = (AW1 > RW) ? AW1 : RW;

  localparam logic [CNT_W-1:0] DEPTH      = CNT_W'(IMAGE_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_LAST = CNT_W'(IMAGE_DEPTH - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_LAST   = IW'(NUM_TESTS - 1);

  seq_state_t       state;
  fail_code_t       fail_code_q;
  fail_code_t       pend_code;
  logic [DATA_WIDTH-1:0] pend_info;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wd_expired;

  assign cnt_next  = cnt + CNT_W'(1);
  assign fail_code = fail_code_q;
  // Write data is only meaningful while strobing; keep it quiet otherwise.
  assign mem_wdata = mem_we ? img_data : '0;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_RUN),
    .enable  (state == ST_RUN),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      img_addr    <= '0;
      tbl_idx     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      core_rst    <= 1'b1;
      core_start  <= 1'b0;
      core_expr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code_q <= FAIL_NONE;
      fail_info   <= '0;
      pend_code   <= FAIL_NONE;
      pend_info   <= '0;
      result      <= '0;
      pass_count  <= '0;
    end else begin
      core_start <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            tbl_idx     <= '0;
            pass_count  <= '0;
            fail_code_q <= FAIL_NONE;
            fail_info   <= '0;
            pass        <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            core_rst    <= 1'b1;
            cnt         <= '0;
            state       <= ST_RST_CORE;
          end
        end

        ST_RST_CORE: begin
          if (cnt == RST_LAST) begin
            cnt      <= '0;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            img_addr <= '0;
            state    <= ST_LOAD;
          end else begin
            cnt <= cnt_next;
          end
        end

        ST_LOAD: begin
          if (cnt == DEPTH_LAST) begin
            cnt      <= '0;
            mem_addr <= '0;
            img_addr <= '0;
            state    <= ST_VERIFY;
          end else begin
            cnt      <= cnt_next;
            mem_we   <= 1'b1;
            mem_addr <= cnt_next[ADDR_WIDTH-1:0];
            img_addr <= cnt_next[ADDR_WIDTH-1:0];
          end
        end

        // RAM data lags its address by one cycle, so the ROM is addressed one
        // word behind the RAM: in step cnt, mem_rdata and img_data both refer
        // to word cnt-1. Step 0 only primes the read; step IMAGE_DEPTH only
        // checks the last word.
        ST_VERIFY: begin
          if ((cnt != '0) && (mem_rdata != img_data)) begin
            pend_code <= FAIL_VERIFY;
            pend_info <= DATA_WIDTH'(img_addr);
            core_rst  <= 1'b1;
            state     <= ST_FAIL;
          end else if (cnt == DEPTH) begin
            core_rst  <= 1'b0;
            core_expr <= tbl_expr;
            state     <= ST_START;
          end else begin
            cnt      <= cnt_next;
            img_addr <= cnt[ADDR_WIDTH-1:0];
            if (cnt_next < DEPTH) begin
              mem_addr <= cnt_next[ADDR_WIDTH-1:0];
            end
          end
        end

        ST_START: begin
          core_start <= 1'b1;
          state      <= ST_RUN;
        end

        ST_RUN: begin
          if (core_error) begin
            pend_code <= FAIL_CORE_ERROR;
            pend_info <= core_err_code;
            core_rst  <= 1'b1;
            state     <= ST_FAIL;
          end else if (core_halt) begin
            state <= ST_CHECK;
          end else if (wd_expired) begin
            pend_code <= FAIL_TIMEOUT;
            pend_info <= '0;
            core_rst  <= 1'b1;
            state     <= ST_FAIL;
          end
        end

        ST_CHECK: begin
          result <= core_val;
          if (core_val == tbl_expected) begin
            if (pass_count != '1) begin
              pass_count <= pass_count + IW'(1);
            end
            state <= ST_NEXT;
          end else begin
            pend_code <= FAIL_CORE_ERROR;
            pend_info <= core_val;
            core_rst  <= 1'b1;
            state     <= ST_FAIL;
          end
        end

        ST_NEXT: begin
          core_rst <= 1'b1;
          if (tbl_idx == IDX_LAST) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            tbl_idx <= tbl_idx + IW'(1);
            cnt     <= '0;
            state   <= ST_RST_CORE;
          end
        end

        ST_FAIL: begin
          fail_code_q <= pend_code;
          fail_info   <= pend_info;
          pass        <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          core_rst    <= 1'b1;
          state       <= ST_DONE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_test_sequencer.sv
module tb_core_test_sequencer;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 32;
  localparam int NT    = 3;
  localparam int RSTC  = 3;
  localparam int TMO   = 64;
  localparam int IW    = $clog2(NT) + 1;
  localparam int LAT   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go  = 1'b0;
  logic [AW-1:0] img_addr;
  logic [DW-1:0] img_data;
  logic [IW-1:0] tbl_idx;
  logic [DW-1:0] tbl_expr, tbl_expected;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          core_rst, core_start;
  logic [DW-1:0] core_expr;
  logic          core_halt, core_error;
  logic [DW-1:0] core_val, core_err_code;
  logic          busy, done, pass;
  logic [1:0]    fail_code;
  logic [DW-1:0] fail_info, result;
  logic [IW-1:0] pass_count;

  always #5 clk = ~clk;

  core_test_sequencer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .IMAGE_DEPTH (DEPTH),
    .NUM_TESTS   (NT),
    .RST_CYCLES  (RSTC),
    .TIMEOUT     (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .img_addr      (img_addr),
    .img_data      (img_data),
    .tbl_idx       (tbl_idx),
    .tbl_expr      (tbl_expr),
    .tbl_expected  (tbl_expected),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .core_rst      (core_rst),
    .core_start    (core_start),
    .core_expr     (core_expr),
    .core_halt     (core_halt),
    .core_error    (core_error),
    .core_val      (core_val),
    .core_err_code (core_err_code),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_code     (fail_code),
    .fail_info     (fail_info),
    .result        (result),
    .pass_count    (pass_count)
  );

  // ROM image and test table
  logic [DW-1:0] rom   [1<<AW];
  logic [DW-1:0] texpr [1<<IW];
  logic [DW-1:0] texp  [1<<IW];
  assign img_data     = rom[img_addr];
  assign tbl_expr     = texpr[tbl_idx];
  assign tbl_expected = texp[tbl_idx];

  // RAM model, optional corruption of word 0x00A on write
  logic [DW-1:0] ram [1<<AW];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_we)
      ram[mem_addr] <= (corrupt && mem_addr == 10'h00A) ? (mem_wdata ^ 16'h0100) : mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Core model: LAT cycles after start, halts with val = car at expr (heap word),
  // or raises error 0005, or hangs.
  int            core_mode = 0;
  logic          running;
  int            ccnt;
  logic [DW-1:0] cexpr;
  always @(posedge clk) begin
    if (core_rst) begin
      running       <= 1'b0;
      ccnt          <= 0;
      core_halt     <= 1'b0;
      core_error    <= 1'b0;
      core_val      <= '0;
      core_err_code <= '0;
      cexpr         <= '0;
    end else if (core_start) begin
      running <= 1'b1;
      ccnt    <= 0;
      cexpr   <= core_expr;
    end else if (running) begin
      ccnt <= ccnt + 1;
      if (ccnt == LAT) begin
        running <= 1'b0;
        case (core_mode)
          0: begin core_halt  <= 1'b1; core_val      <= ram[cexpr[AW-1:0]]; end
          1: begin core_error <= 1'b1; core_err_code <= 16'h0005; end
          default: ;
        endcase
      end
    end
  end

  // Scoreboards
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct {
    bit            p;
    logic [1:0]    code;
    logic [DW-1:0] info;
    int            pc;
    int            idx;
    int            starts;
  } res_t;
  wr_t  exp_wr [$];
  res_t res_q  [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;
  int first_wr_cyc = 0;
  int done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; compare every RAM write against the write scoreboard.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (mem_we) begin
      checks++;
      assert (exp_wr.size() != 0) else begin
        errors++;
        $error("FAIL write_expected: observed write addr=%h data=%h, expected none", mem_addr, mem_wdata);
      end
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(w.a));
        chk("write_data", 32'(mem_wdata), 32'(w.d));
      end
      if (mem_addr == '0) first_wr_cyc = cyc;
    end
    if (core_start) begin
      starts++;
      start_cyc = cyc;
    end
  endtask

  task automatic push_writes(input int nloads);
    wr_t w;
    for (int t = 0; t < nloads; t++)
      for (int k = 0; k < DEPTH; k++) begin
        w.a = AW'(k);
        w.d = rom[k];
        exp_wr.push_back(w);
      end
  endtask

  task automatic run_batch(input string name, input bit p, input logic [1:0] code,
                           input logic [DW-1:0] info, input int pc, input int idx,
                           input int nstarts, input int nloads, input bit extra_go);
    res_t e, r;
    int s0, n;
    e.p = p; e.code = code; e.info = info; e.pc = pc; e.idx = idx; e.starts = nstarts;
    push_writes(nloads);
    res_q.push_back(e);
    s0 = starts;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    if (extra_go) begin
      n = 0;
      while (starts == s0 && n < 2000) begin tick(); n++; end
      chk({name, "_first_start"}, 32'(starts - s0), 32'd1);
      go = 1'b1; tick(); go = 1'b0; tick();
      go = 1'b1; tick(); go = 1'b0;
    end
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    done_cyc = cyc;
    chk({name, "_done"}, 32'(done), 32'd1);
    r = res_q.pop_front();
    chk({name, "_pass"},       32'(pass),        32'(r.p));
    chk({name, "_fail_code"},  32'(fail_code),   32'(r.code));
    chk({name, "_fail_info"},  32'(fail_info),   32'(r.info));
    chk({name, "_pass_count"}, 32'(pass_count),  32'(r.pc));
    chk({name, "_tbl_idx"},    32'(tbl_idx),     32'(r.idx));
    chk({name, "_starts"},     32'(starts - s0), 32'(r.starts));
    chk({name, "_busy_end"},   32'(busy),        32'd0);
    chk({name, "_core_rst"},   32'(core_rst),    32'd1);
    chk({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    exp_wr.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < (1<<AW); k++) rom[k] = DW'(k * 16'h0101 + 16'h0011);
    rom[3] = 16'h0034;
    for (int i = 0; i < (1<<IW); i++) begin
      texpr[i] = 16'h0003;
      texp[i]  = 16'h0034;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_core_rst",   32'(core_rst),   32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_pass",       32'(pass),       32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_fail_code",  32'(fail_code),  32'd0);
    chk("rst_pass_count", 32'(pass_count), 32'd0);
    chk("rst_img_addr",   32'(img_addr),   32'd0);
    chk("rst_result",     32'(result),     32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // 1: all tests pass on the cons/car image
    core_mode = 0;
    run_batch("pass_all", 1'b1, 2'd0, 16'h0000, NT, NT-1, NT, NT, 1'b0);
    chk("pass_all_result", 32'(result), 32'h0034);
    chk("pass_all_core_expr", 32'(core_expr), 32'h0003);
    chk("load_verify_latency", 32'(start_cyc - first_wr_cyc), 32'(2*DEPTH + 2));

    // 2: corrupted RAM word 0x00A
    corrupt = 1'b1;
    run_batch("verify_fail", 1'b0, 2'd1, 16'h000A, 0, 0, 0, 1, 1'b0);
    corrupt = 1'b0;

    // 3: core error code 0005
    core_mode = 1;
    run_batch("core_err", 1'b0, 2'd2, 16'h0005, 0, 0, 1, 1, 1'b0);

    // 4: core hangs -> timeout TMO cycles after the start pulse, then FAIL, DONE
    core_mode = 2;
    run_batch("timeout", 1'b0, 2'd3, 16'h0000, 0, 0, 1, 1, 1'b0);
    chk("timeout_cycles", 32'(done_cyc - start_cyc), 32'(TMO + 2));

    // 5: second expected value wrong
    core_mode = 0;
    texp[1] = 16'h0035;
    run_batch("wrong_val", 1'b0, 2'd2, 16'h0034, 1, 1, 2, 2, 1'b0);
    chk("wrong_val_result", 32'(result), 32'h0034);
    texp[1] = 16'h0034;

    // 6: reset mid-LOAD, then go pulses during RUN are ignored
    push_writes(1);
    go = 1'b1; tick(); go = 1'b0;
    for (int n = 0; n < 200 && !(mem_we && mem_addr == 10'd5); n++) tick();
    chk("midload_reached", 32'(mem_we && mem_addr == 10'd5), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_we",   32'(mem_we),   32'd0);
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_done",     32'(done),     32'd0);
    exp_wr.delete();
    repeat (3) tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_batch("restart", 1'b1, 2'd0, 16'h0000, NT, NT-1, NT, NT, 1'b1);
    chk("restart_result", 32'(result), 32'h0034);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
